// File: rtl/cordic_pkg.sv
// rtl/cordic_pkg.sv - shared angle constants, sequencer state type and dither LFSR helpers
package cordic_pkg;

  // pi in 3.29 signed fixed point, carried at 34 bits so 2*pi never overflows
  localparam logic [33:0] PI_Q3_29 = 34'h0_6487ED51;

  function automatic logic signed [33:0] pi_const(input int angle_width);
    return $signed(PI_Q3_29) >>> (32 - angle_width);
  endfunction

  function automatic logic signed [33:0] pi_2_const(input int angle_width);
    return pi_const(angle_width) >>> 1;
  endfunction

  function automatic logic signed [33:0] two_pi_const(input int angle_width);
    return pi_const(angle_width) <<< 1;
  endfunction

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    HOLD
  } nco_state_t;

  function automatic logic [15:0] lfsr_seed();
    return 16'hACE1;
  endfunction

  // Fibonacci taps 16,14,13,11 seen from the shift-right form (bits 0,2,3,5)
  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
  endfunction

endpackage

// File: rtl/cordic_phase_wrap.sv
// rtl/cordic_phase_wrap.sv - combinational phase add with [-pi, pi) wrap and increment range check
module cordic_phase_wrap
  import cordic_pkg::*;
#(
  parameter int ANGLE_WIDTH = 32
) (
  input  logic [ANGLE_WIDTH-1:0] base,
  input  logic [ANGLE_WIDTH-1:0] inc,
  output logic [ANGLE_WIDTH-1:0] sum,
  output logic                   inc_legal
);

  localparam int AW = ANGLE_WIDTH;
  localparam logic signed [33:0] PI_FULL = pi_const(AW);
  localparam logic signed [33:0] TWO_PI_FULL = two_pi_const(AW);
  localparam logic signed [AW+1:0] PI_W = PI_FULL[AW+1:0];
  localparam logic signed [AW+1:0] NEG_PI_W = -PI_W;
  localparam logic signed [AW+1:0] TWO_PI_W = TWO_PI_FULL[AW+1:0];

  logic signed [AW+1:0] base_x;
  logic signed [AW+1:0] inc_x;
  logic signed [AW+1:0] inc_eff;
  logic signed [AW+1:0] raw;
  logic signed [AW+1:0] wrapped;

  assign base_x = {{2{base[AW-1]}}, base};
  assign inc_x  = {{2{inc[AW-1]}}, inc};

  // an out-of-range increment contributes nothing rather than corrupting the phase
  assign inc_legal = (inc_x < PI_W) && (inc_x >= NEG_PI_W);
  assign inc_eff   = inc_legal ? inc_x : '0;
  assign raw       = base_x + inc_eff;

  always_comb begin
    wrapped = raw;
    if (raw >= PI_W) begin
      wrapped = raw - TWO_PI_W;
    end else if (raw < NEG_PI_W) begin
      wrapped = raw + TWO_PI_W;
    end
  end

  assign sum = wrapped[AW-1:0];

endmodule

// File: rtl/cordic_nco_sequencer.sv
// rtl/cordic_nco_sequencer.sv - NCO phase accumulator and start/done/sample sequencer for the CORDIC rotator; CORDIC_NCO_DITHER_EN adds LFSR angle dither
module cordic_nco_sequencer
  import cordic_pkg::*;
#(
  parameter int               WIDTH          = 16,
  parameter int               ANGLE_WIDTH    = 32,
  parameter logic [WIDTH-1:0] X_INIT         = WIDTH'(16'h26DD),
  parameter int               TIMEOUT_CYCLES = 64,
  parameter int               DITHER_BITS    = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   enable,
  input  logic [ANGLE_WIDTH-1:0] phase_inc,
  input  logic                   phase_load,
  input  logic [ANGLE_WIDTH-1:0] phase_init,
  output logic                   cordic_start,
  output logic [ANGLE_WIDTH-1:0] cordic_angle,
  output logic [WIDTH-1:0]       cordic_x_start,
  output logic [WIDTH-1:0]       cordic_y_start,
  input  logic                   cordic_done,
  input  logic [WIDTH-1:0]       cordic_cos,
  input  logic [WIDTH-1:0]       cordic_sin,
  output logic                   sample_valid,
  input  logic                   sample_ready,
  output logic [WIDTH-1:0]       sample_cos,
  output logic [WIDTH-1:0]       sample_sin,
  output logic                   cfg_error,
  output logic                   timeout_error
);

  localparam int AW = ANGLE_WIDTH;
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  if (AW < 16 || AW > 32 || DITHER_BITS < 1 || DITHER_BITS > 15 || TIMEOUT_CYCLES < 2) begin : g_bad_params
    $error("cordic_nco_sequencer: unsupported parameter combination");
  end

  nco_state_t state;
  nco_state_t state_next;

  logic [AW-1:0]    phase;
  logic [AW-1:0]    phase_stepped;
  logic [AW-1:0]    init_value;
  logic [AW-1:0]    angle_w;
  logic             inc_ok;
  logic             init_ok;
  logic [CNT_W-1:0] wait_cnt;
  logic             timeout_hit;
  logic             capture;
  logic             timeout_fire;
  logic             handshake;

  assign cordic_x_start = X_INIT;
  assign cordic_y_start = '0;
  assign timeout_hit    = (wait_cnt == CNT_LAST);

  cordic_phase_wrap #(.ANGLE_WIDTH(AW)) u_acc_wrap (
    .base      (phase),
    .inc       (phase_inc),
    .sum       (phase_stepped),
    .inc_legal (inc_ok)
  );

  // 0 + phase_init reuses the same range check; a legal value passes through unwrapped
  cordic_phase_wrap #(.ANGLE_WIDTH(AW)) u_init_check (
    .base      ('0),
    .inc       (phase_init),
    .sum       (init_value),
    .inc_legal (init_ok)
  );

`ifdef CORDIC_NCO_DITHER_EN
  logic [15:0] lfsr;
  logic [AW-1:0] dither_inc;
  logic dither_ok;

  always_ff @(posedge clock) begin
    if (reset) begin
      lfsr <= lfsr_seed();
    end else if (cordic_start) begin
      lfsr <= lfsr_step(lfsr);
    end
  end

  assign dither_inc = AW'(lfsr[DITHER_BITS-1:0]);

  // dither perturbs only the presented angle; the accumulator itself stays clean
  cordic_phase_wrap #(.ANGLE_WIDTH(AW)) u_dither_wrap (
    .base      (phase),
    .inc       (dither_inc),
    .sum       (angle_w),
    .inc_legal (dither_ok)
  );
`else
  assign angle_w = phase;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (enable) state_next = ISSUE;
      ISSUE:   state_next = WAIT;
      WAIT: begin
        if (cordic_done) begin
          state_next = HOLD;
        end else if (timeout_hit) begin
          state_next = IDLE;
        end
      end
      HOLD:    if (sample_ready) state_next = enable ? ISSUE : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    cordic_start = 1'b0;
    cordic_angle = '0;
    capture      = 1'b0;
    timeout_fire = 1'b0;
    handshake    = 1'b0;
    case (state)
      ISSUE: begin
        cordic_start = 1'b1;
        cordic_angle = angle_w;
      end
      WAIT: begin
        capture      = cordic_done;
        timeout_fire = !cordic_done && timeout_hit;
      end
      HOLD:    handshake = sample_valid && sample_ready;
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      phase         <= '0;
      wait_cnt      <= '0;
      sample_valid  <= 1'b0;
      sample_cos    <= '0;
      sample_sin    <= '0;
      cfg_error     <= 1'b0;
      timeout_error <= 1'b0;
    end else begin
      // a load lands even on an ISSUE cycle, after that ISSUE has presented the old phase
      if (phase_load && init_ok) begin
        phase <= init_value;
      end else if (cordic_start) begin
        phase <= phase_stepped;
      end

      if (cordic_start) begin
        wait_cnt <= '0;
      end else if (state == WAIT) begin
        wait_cnt <= wait_cnt + 1'b1;
      end

      if ((cordic_start && !inc_ok) || (phase_load && !init_ok)) begin
        cfg_error <= 1'b1;
      end

      if (capture) begin
        sample_valid <= 1'b1;
        sample_cos   <= cordic_cos;
        sample_sin   <= cordic_sin;
      end else if (handshake) begin
        sample_valid <= 1'b0;
      end

      if (timeout_fire) begin
        timeout_error <= 1'b1;
      end
    end
  end

endmodule

// File: doc/cordic_nco_sequencer.md
Name: cordic_nco_sequencer

Overview:
- Upstream phase generator and handshake sequencer for the single-cycle-normalization CORDIC rotator.
- Keeps a signed phase accumulator, issues one start per sample, waits for done and captures cosine/sine.
- Presents each result on a valid/ready output with backpressure; no new rotation starts until the held sample is consumed.

Parameters:
WIDTH, 16, coordinate/result width, matches the CORDIC WIDTH
ANGLE_WIDTH, 32, angle width; supported range 16..32; 3 integer bits, ANGLE_WIDTH-3 fractional bits
X_INIT, 16'h26DD, constant driven on cordic_x_start (gain-compensated unit vector)
TIMEOUT_CYCLES, 64, maximum cycles in WAIT before an error; must be ≥ CORDIC latency (ITERATIONS+3)
DITHER_BITS, 4, number of angle LSBs perturbed when dither is compiled in

Ports:
clock  in  1  system clock, rising edge
reset  in  1  synchronous, active-high
enable  in  1  run request; sampled in IDLE and at each handshake
phase_inc  in  ANGLE_WIDTH  signed per-sample increment; legal range [-PI, PI)
phase_load  in  1  load phase_init into accumulator (1-cycle strobe)
phase_init  in  ANGLE_WIDTH  signed load value; legal range [-PI, PI)
cordic_start  out  1  one-cycle start pulse
cordic_angle  out  ANGLE_WIDTH  angle presented with start
cordic_x_start  out  WIDTH  constant X_INIT
cordic_y_start  out  WIDTH  constant 0
cordic_done  in  1  CORDIC completion pulse
cordic_cos  in  WIDTH  CORDIC cosine, valid with done
cordic_sin  in  WIDTH  CORDIC sine, valid with done
sample_valid  out  1  output sample held
sample_ready  in  1  consumer accepts
sample_cos  out  WIDTH  held cosine
sample_sin  out  WIDTH  held sine
cfg_error  out  1  sticky: illegal phase_inc or phase_init seen
timeout_error  out  1  sticky: done missing within TIMEOUT_CYCLES

Behaviour:
- Reset values: all outputs 0 except cordic_x_start=X_INIT. Phase=0, state=IDLE, both error flags cleared.
- Constants: PI = 32'h6487ED51 arithmetically shifted right by (32-ANGLE_WIDTH); TWO_PI = 2*PI, computed at ANGLE_WIDTH+2 bits.
- The accumulator always stays in [-PI, PI), so the signed angle never overflows.
- Wrap rule: sum = phase + inc, computed at ANGLE_WIDTH+2 bits.
  - If sum ≥ PI: sum − TWO_PI.
  - Else if sum < −PI: sum + TWO_PI.
  - Else: sum.
- phase_inc is out of range if phase_inc ≥ PI or phase_inc < −PI. In that case the increment is treated as 0 for that update and cfg_error is set.
- FSM states:
  - IDLE: if enable, go to ISSUE. cordic_done is ignored here.
  - ISSUE (1 cycle): cordic_start=1, cordic_angle=phase. Phase updates to wrap(phase+phase_inc). Clear the timeout counter. Go to WAIT.
  - WAIT: on cordic_done, register cordic_cos/cordic_sin into sample_cos/sample_sin, set sample_valid=1, go to HOLD. Otherwise increment the counter. When the counter reaches TIMEOUT_CYCLES-1 without done, set timeout_error and go to IDLE; no sample is produced.
  - HOLD: when sample_valid && sample_ready, clear sample_valid. Then, in that same cycle, go to ISSUE if enable, else IDLE.
- Sample-to-sample latency: 1 (ISSUE) + CORDIC latency + 1 (capture) + consumer wait; minimum one HOLD cycle.
- sample_cos/sample_sin remain stable while sample_valid=1 and sample_ready=0.
- phase_load:
  - Accepted in any state; wins over the ISSUE update in the same cycle.
  - The angle emitted in that ISSUE is the pre-load phase.
  - An out-of-range phase_init is ignored and sets cfg_error.
- Deasserting enable mid-operation does not abort. The in-flight sample completes and is delivered, then the block returns to IDLE.
- A second cordic_done while in HOLD is ignored (it cannot occur legally).
- Reset mid-WAIT: return to IDLE immediately; a later stray done is ignored.
- Error flags clear only on reset.

Optional Feature:
- Macro: CORDIC_NCO_DITHER_EN.
- When defined:
  - A 16-bit Fibonacci LFSR (taps 16,14,13,11, seed 16'hACE1 on reset) advances once per ISSUE.
  - Its DITHER_BITS LSBs are added to cordic_angle only; the accumulator is not dithered.
  - The sum is re-wrapped with the same rule.
- When undefined: cordic_angle equals the accumulator exactly and no LFSR exists.

Decomposition:
- Package cordic_pkg holds:
  - the PI/PI_2/TWO_PI constant functions of ANGLE_WIDTH;
  - the FSM state typedef (IDLE, ISSUE, WAIT, HOLD);
  - the LFSR seed and taps.
- One natural sub-module: cordic_phase_wrap, a combinational add-and-wrap with range check. It is used for both the accumulator update and dither re-wrap.

Test Plan:
- phase_inc=32'h1921FB54, enable=1, CORDIC model that returns done after 18 cycles:
  - emitted angles are 0, 1921FB54, 3243F6A8, 4B65F1FC, 6487ED50, then −32'h4B65F1FE (wrapped);
  - exactly one start per sample.
- sample_ready held low 50 cycles after the first sample:
  - sample_valid stays 1 with stable values;
  - no cordic_start until the handshake;
  - ISSUE occurs in the handshake cycle+1.
- CORDIC model never asserts done, TIMEOUT_CYCLES=64:
  - timeout_error=1 exactly 64 cycles after start;
  - state returns to IDLE with no sample_valid.
- phase_inc=32'h70000000 (≥PI):
  - cfg_error=1;
  - emitted angles repeat unchanged.
- phase_load with phase_init=32'hA0000000 coincident with ISSUE:
  - next emitted angle is A0000000;
  - phase_init=32'h90000000 (<−PI) is ignored and sets cfg_error.
- Reset asserted in WAIT, then done pulsed 5 cycles later:
  - all outputs return to reset values;
  - no sample_valid;
  - sequence restarts from angle 0.
